alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Downstream consumer of the running clock's packed time word {hours, tens-min, ones-min, tens-sec, ones-sec}.
- Holds a user-set alarm time (hour, tens-min, ones-min), adjustable with single-cycle button edge pulses.
- Detects when the running time reaches HH:MM:00, then drives a square-wave buzzer.
- Supports snooze, dismiss and an automatic ring timeout.

Parameters:
- TICK_DIV, 100000000, CLK100MHZ cycles per internal 1 s tick.
- RING_TICKS, 60, ticks of ringing before automatic return to IDLE.
- SNOOZE_TICKS, 300, ticks spent in SNOOZE before re-ringing.
- TONE_HALF, 50000, cycles per buzzer half-period (1 kHz at 100 MHz).

Ports:
- CLK100MHZ  in  1  system clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- time_in  in  18  {hours[17:14], tmin[13:11], omin[10:7], tsec[6:4], osec[3:0]} from the clock counters.
- arm  in  1  level; 1 enables alarm triggering.
- set_en  in  1  level; 1 enables editing of the alarm time and suppresses triggering.
- sel_pulse  in  1  one-cycle pulse; advances the edit field.
- inc_pulse  in  1  one-cycle pulse; increments the selected field.
- dec_pulse  in  1  one-cycle pulse; decrements the selected field.
- snooze_pulse  in  1  one-cycle pulse; requests snooze.
- dismiss_pulse  in  1  one-cycle pulse; requests dismiss.
- alarm_time  out  11  {a_hour[10:7], a_tmin[6:4], a_omin[3:0]}.
- sel  out  2  edit field: 0 = ones-min, 1 = tens-min, 2 = hour.
- alarm_active  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- buzzer  out  1  tone output.

Behaviour:
- Clocking and reset:
  - All state updates on the posedge of CLK100MHZ.
  - rst has priority over every other input.
  - On rst: alarm_time = 0, sel = 0, state = IDLE, alarm_active = 0, snoozing = 0, buzzer = 0, match_prev = 0, all counters = 0.
  - rst asserted mid-RINGING or mid-SNOOZE returns the block to IDLE on the next edge.
- Editing (active only when set_en = 1):
  - sel_pulse: sel steps 0 -> 1 -> 2 -> 0.
  - Field ranges and wrap on inc/dec:
    - ones-min: 0..9; inc 9 -> 0, dec 0 -> 9.
    - tens-min: 0..5; inc 5 -> 0, dec 0 -> 5.
    - hour: 0..12; inc 12 -> 0, dec 0 -> 12.
  - inc_pulse and dec_pulse in the same cycle: no change.
  - sel_pulse in the same cycle as inc/dec: the inc/dec applies to the old sel; sel then advances.
  - With set_en = 0, all edit pulses are ignored.
  - Editing is allowed in any state and does not itself alter the state.
- Match detection:
  - match_now = (time_in[17:7] == alarm_time) && tsec == 0 && osec == 0 (combinational).
  - match_prev is registered every cycle.
  - trigger = match_now & ~match_prev & arm & ~set_en & (state == IDLE).
  - The alarm fires once per entry into the matching second; staying matched does not re-fire.
- State machine (2-bit state):
  - IDLE:
    - trigger -> RINGING; alarm_active = 1 on the cycle after the trigger cycle (1-cycle latency).
  - RINGING:
    - dismiss_pulse -> IDLE.
    - else snooze_pulse -> SNOOZE.
    - else timeout after RING_TICKS ticks -> IDLE.
    - Dismiss wins over snooze when both arrive in the same cycle.
  - SNOOZE:
    - dismiss_pulse -> IDLE.
    - else timeout after SNOOZE_TICKS ticks -> RINGING.
    - snooze_pulse is ignored.
    - time_in matches are ignored.
  - arm = 0 in any state forces IDLE on the next edge.
- Timing:
  - The tick counter and tick-count register clear on every entry into RINGING or SNOOZE.
  - A tick fires when the tick counter reaches TICK_DIV-1; the counter then wraps to 0.
  - The timeout occurs on the RING_TICKS-th (or SNOOZE_TICKS-th) tick.
  - Exact dwell before the state change is RING_TICKS*TICK_DIV cycles (or SNOOZE_TICKS*TICK_DIV).
- Buzzer:
  - buzzer = 0 outside RINGING.
  - On entry into RINGING: buzzer = 1 and the tone counter = 0.
  - buzzer toggles each time the tone counter reaches TONE_HALF-1; the counter then wraps to 0.
  - Resulting period is 2*TONE_HALF cycles.
  - buzzer drops to 0 on the same edge that leaves RINGING.
- Counter widths: sized with $clog2 of the parameter; no counter overflows at the default values.

Test Plan:
- Bench uses TICK_DIV = 10, RING_TICKS = 3, SNOOZE_TICKS = 2, TONE_HALF = 4.
- Edit/wrap:
  - Stimulus: set_en = 1, sel = 2, 13 inc_pulses, then 1 dec_pulse.
  - Required: hour reads 12 after 12 incs, 0 after the 13th inc, 12 after the dec.
  - Then sel to 0 with tens-min at 5: inc leaves alarm_time = {12, 5, 0}.
- Trigger:
  - Setup: alarm = 7:30, arm = 1, set_en = 0.
  - Stimulus: time_in steps 7:29:59 -> 7:30:00 at cycle N.
  - Required: alarm_active = 1 at N+1; buzzer = 1 at N+1, 0 at N+5, 1 at N+9.
  - Holding time_in at 7:30:00 produces no re-trigger.
- Timeout:
  - Stimulus: after entry into RINGING, apply no input.
  - Required: alarm_active stays 1 for exactly 30 cycles, then 0 and buzzer = 0.
- Snooze cycle:
  - Stimulus: snooze_pulse while RINGING.
  - Required: snoozing = 1, buzzer = 0 on the next edge.
  - Required: after 20 cycles, RINGING again with buzzer = 1.
  - A snooze_pulse during SNOOZE changes nothing.
- Priority:
  - Stimulus: snooze_pulse and dismiss_pulse in the same cycle.
  - Required: IDLE on the next edge.
  - Stimulus: inc_pulse and dec_pulse in the same cycle.
  - Required: alarm_time unchanged.
- Suppression/reset:
  - Stimulus: match edge with set_en = 1, or with arm = 0.
  - Required: no trigger.
  - Stimulus: rst asserted mid-SNOOZE.
  - Required: next edge shows all outputs at 0 and alarm_time = 0.

Source files
------------

// File: rtl/alarm_controller.sv
// alarm_controller
// Holds a user-editable alarm time (hour, tens-min, ones-min), watches the
// running clock's packed time word and rings a square-wave buzzer when the
// time reaches HH:MM:00. Ringing ends on dismiss, on snooze (which re-rings
// after a delay) or on an automatic timeout.
module alarm_controller #(
    parameter int TICK_DIV     = 100000000,
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int TONE_HALF    = 50000
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic [17:0] time_in,
    input  logic        arm,
    input  logic        set_en,
    input  logic        sel_pulse,
    input  logic        inc_pulse,
    input  logic        dec_pulse,
    input  logic        snooze_pulse,
    input  logic        dismiss_pulse,
    output logic [10:0] alarm_time,
    output logic [1:0]  sel,
    output logic        alarm_active,
    output logic        snoozing,
    output logic        buzzer
);

    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS + 1) : 1;
    localparam int TONE_W    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  RING_LAST   = CNT_W'(RING_TICKS - 1);
    localparam logic [CNT_W-1:0]  SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);
    localparam logic [TONE_W-1:0] TONE_LAST   = TONE_W'(TONE_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_a_hour;
    logic [2:0]          r_a_tmin;
    logic [3:0]          r_a_omin;
    logic [1:0]          r_sel;
    logic                r_match_prev;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [CNT_W-1:0]    r_tick_num;
    logic [TONE_W-1:0]   r_tone_cnt;
    logic                r_buzzer;

    logic                w_match_now;
    logic                w_trigger;
    logic                w_inc;
    logic                w_dec;
    logic                w_tick;
    logic                w_ring_timeout;
    logic                w_snooze_timeout;
    logic                w_enter_timed;
    logic [3:0]          w_omin_step;
    logic [3:0]          w_tmin_step;
    logic [3:0]          w_hour_step;

    // One step of a wrapping 0..max_value field; up and down are never both set.
    function automatic logic [3:0] wrap_step(input logic [3:0] value,
                                             input logic [3:0] max_value,
                                             input logic       up,
                                             input logic       down);
        logic [3:0] result;
        result = value;
        if (up) begin
            result = (value >= max_value) ? 4'd0 : value + 4'd1;
        end else if (down) begin
            result = (value == 4'd0) ? max_value : value - 4'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    assign alarm_time = {r_a_hour, r_a_tmin, r_a_omin};
    assign sel        = r_sel;
    assign buzzer     = r_buzzer;

    // Simultaneous inc and dec cancel out; nothing edits while set_en is low.
    assign w_inc = set_en & inc_pulse & ~dec_pulse;
    assign w_dec = set_en & dec_pulse & ~inc_pulse;

    assign w_omin_step = wrap_step(r_a_omin, 4'd9, w_inc, w_dec);
    assign w_tmin_step = wrap_step({1'b0, r_a_tmin}, 4'd5, w_inc, w_dec);
    assign w_hour_step = wrap_step(r_a_hour, 4'd12, w_inc, w_dec);

    // Fire only on the first cycle of the matching HH:MM:00 second.
    assign w_match_now = (time_in[17:7] == alarm_time) && (time_in[6:4] == 3'd0)
                         && (time_in[3:0] == 4'd0);
    assign w_trigger   = w_match_now & ~r_match_prev & arm & ~set_en & (r_state == ST_IDLE);

    assign w_tick           = (r_tick_cnt == TICK_LAST);
    assign w_ring_timeout   = w_tick && (r_tick_num == RING_LAST);
    assign w_snooze_timeout = w_tick && (r_tick_num == SNOOZE_LAST);
    assign w_enter_timed    = (w_next_state != r_state)
                              && ((w_next_state == ST_RINGING) || (w_next_state == ST_SNOOZE));

    // Alarm field editing and edit-field selection.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_a_hour <= 4'd0;
            r_a_tmin <= 3'd0;
            r_a_omin <= 4'd0;
            r_sel    <= 2'd0;
        end else begin
            if (w_inc || w_dec) begin
                case (r_sel)
                    2'd0:    r_a_omin <= w_omin_step;
                    2'd1:    r_a_tmin <= w_tmin_step[2:0];
                    2'd2:    r_a_hour <= w_hour_step;
                    default: r_a_omin <= r_a_omin;
                endcase
            end
            if (set_en && sel_pulse) begin
                r_sel <= (r_sel >= 2'd2) ? 2'd0 : r_sel + 2'd1;
            end
        end
    end

    // State register and previous-cycle match flag.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_match_prev <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_match_prev <= w_match_now;
        end
    end

    // Next-state selection; disarming overrides everything, dismiss beats snooze.
    always_comb begin
        w_next_state = r_state;
        if (!arm) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        w_next_state = ST_RINGING;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_RINGING: begin
                    if (dismiss_pulse) begin
                        w_next_state = ST_IDLE;
                    end else if (snooze_pulse) begin
                        w_next_state = ST_SNOOZE;
                    end else if (w_ring_timeout) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_RINGING;
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss_pulse) begin
                        w_next_state = ST_IDLE;
                    end else if (w_snooze_timeout) begin
                        w_next_state = ST_RINGING;
                    end else begin
                        w_next_state = ST_SNOOZE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        alarm_active = (r_state == ST_RINGING);
        snoozing     = (r_state == ST_SNOOZE);
    end

    // One-second tick divider and tick count, restarted on each timed-state entry.
    always_ff @(posedge CLK100MHZ) begin
        if (rst || w_enter_timed || (w_next_state == ST_IDLE)) begin
            r_tick_cnt <= '0;
            r_tick_num <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_tick_num <= r_tick_num + CNT_W'(1);
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Buzzer tone: starts high on entry to ringing, toggles every TONE_HALF cycles.
    always_ff @(posedge CLK100MHZ) begin
        if (rst || (w_next_state != ST_RINGING)) begin
            r_buzzer   <= 1'b0;
            r_tone_cnt <= '0;
        end else if (r_state != ST_RINGING) begin
            r_buzzer   <= 1'b1;
            r_tone_cnt <= '0;
        end else if (r_tone_cnt == TONE_LAST) begin
            r_buzzer   <= ~r_buzzer;
            r_tone_cnt <= '0;
        end else begin
            r_tone_cnt <= r_tone_cnt + TONE_W'(1);
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller
// Directed scenarios plus randomized traffic, every cycle compared against a
// behavioural model that tracks the mode and the cycles spent in it.
module tb_alarm_controller;

    localparam int TICK_DIV     = 10;
    localparam int RING_TICKS   = 3;
    localparam int SNOOZE_TICKS = 2;
    localparam int TONE_HALF    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] time_in;
    logic        arm, set_en, sel_pulse, inc_pulse, dec_pulse, snooze_pulse, dismiss_pulse;
    logic [10:0] alarm_time;
    logic [1:0]  sel;
    logic        alarm_active, snoozing, buzzer;

    int errors = 0;
    int checks = 0;

    // model state: mode 0 idle, 1 ringing, 2 snooze; dwell = cycles since entry
    int m_hour, m_tmin, m_omin, m_sel, m_mode, m_dwell;
    bit m_prev;

    always #5 clk = ~clk;

    alarm_controller #(
        .TICK_DIV(TICK_DIV), .RING_TICKS(RING_TICKS),
        .SNOOZE_TICKS(SNOOZE_TICKS), .TONE_HALF(TONE_HALF)
    ) dut (
        .CLK100MHZ(clk), .rst(rst), .time_in(time_in), .arm(arm), .set_en(set_en),
        .sel_pulse(sel_pulse), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .snooze_pulse(snooze_pulse), .dismiss_pulse(dismiss_pulse),
        .alarm_time(alarm_time), .sel(sel), .alarm_active(alarm_active),
        .snoozing(snoozing), .buzzer(buzzer)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(input int v, input int maxv, input int delta);
        return (v + delta + maxv + 1) % (maxv + 1);
    endfunction

    function automatic logic [17:0] tval(input int h, input int tm, input int om,
                                         input int ts, input int os);
        return {4'(h), 3'(tm), 4'(om), 3'(ts), 4'(os)};
    endfunction

    function automatic int exp_alarm();
        return m_hour * 128 + m_tmin * 16 + m_omin;
    endfunction

    function automatic int exp_buzzer();
        return (m_mode == 1 && ((m_dwell / TONE_HALF) % 2) == 0) ? 1 : 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit match, trig;
        int n_mode, delta;
        match = (int'(time_in[17:14]) == m_hour) && (int'(time_in[13:11]) == m_tmin)
                && (int'(time_in[10:7]) == m_omin) && (time_in[6:0] == 7'd0);
        if (rst) begin
            m_hour = 0; m_tmin = 0; m_omin = 0; m_sel = 0;
            m_mode = 0; m_dwell = 0; m_prev = 1'b0;
        end else begin
            trig = match && !m_prev && arm && !set_en && (m_mode == 0);
            if (!arm) n_mode = 0;
            else if (m_mode == 0) n_mode = trig ? 1 : 0;
            else if (m_mode == 1) begin
                if (dismiss_pulse) n_mode = 0;
                else if (snooze_pulse) n_mode = 2;
                else if (m_dwell + 1 == RING_TICKS * TICK_DIV) n_mode = 0;
                else n_mode = 1;
            end else begin
                if (dismiss_pulse) n_mode = 0;
                else if (m_dwell + 1 == SNOOZE_TICKS * TICK_DIV) n_mode = 1;
                else n_mode = 2;
            end
            m_dwell = (n_mode != m_mode || n_mode == 0) ? 0 : m_dwell + 1;
            m_mode  = n_mode;
            if (set_en) begin
                if (inc_pulse != dec_pulse) begin
                    delta = inc_pulse ? 1 : -1;
                    case (m_sel)
                        0: m_omin = wrap(m_omin, 9, delta);
                        1: m_tmin = wrap(m_tmin, 5, delta);
                        default: m_hour = wrap(m_hour, 12, delta);
                    endcase
                end
                if (sel_pulse) m_sel = (m_sel + 1) % 3;
            end
            m_prev = match;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_val("alarm_time", alarm_time, exp_alarm());
        check_val("sel", sel, m_sel);
        check_val("alarm_active", alarm_active, (m_mode == 1) ? 1 : 0);
        check_val("snoozing", snoozing, (m_mode == 2) ? 1 : 0);
        check_val("buzzer", buzzer, exp_buzzer());
        sel_pulse = 0; inc_pulse = 0; dec_pulse = 0; snooze_pulse = 0; dismiss_pulse = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int r;
        rst = 1; time_in = '0; arm = 0; set_en = 0;
        sel_pulse = 0; inc_pulse = 0; dec_pulse = 0; snooze_pulse = 0; dismiss_pulse = 0;
        m_hour = 0; m_tmin = 0; m_omin = 0; m_sel = 0; m_mode = 0; m_dwell = 0; m_prev = 0;
        step(); step();
        rst = 0;
        check_val("reset_alarm_time", alarm_time, 0);
        check_val("reset_buzzer", buzzer, 0);

        // edit: hour wrap
        set_en = 1;
        sel_pulse = 1; step();
        sel_pulse = 1; step();
        check_val("sel_hour", sel, 2);
        for (int i = 1; i <= 13; i++) begin
            inc_pulse = 1; step();
            if (i == 12) check_val("hour_at_12", alarm_time[10:7], 12);
        end
        check_val("hour_wrap_0", alarm_time[10:7], 0);
        dec_pulse = 1; step();
        check_val("hour_dec_12", alarm_time[10:7], 12);
        sel_pulse = 1; step();
        sel_pulse = 1; step();
        dec_pulse = 1; step();
        check_val("tmin_dec_5", alarm_time[6:4], 5);
        sel_pulse = 1; step();
        sel_pulse = 1; step();
        dec_pulse = 1; step();
        check_val("omin_dec_9", alarm_time[3:0], 9);
        inc_pulse = 1; step();
        check_val("edit_12_5_0", alarm_time, 12 * 128 + 5 * 16);
        inc_pulse = 1; dec_pulse = 1; step();
        check_val("inc_dec_same", alarm_time, 12 * 128 + 5 * 16);
        sel_pulse = 1; inc_pulse = 1; step();
        check_val("sel_inc_value", alarm_time, 12 * 128 + 5 * 16 + 1);
        check_val("sel_inc_sel", sel, 1);

        // program 7:30
        set_en = 0; rst = 1; step(); rst = 0;
        set_en = 1;
        sel_pulse = 1; step();
        repeat (3) begin inc_pulse = 1; step(); end
        sel_pulse = 1; step();
        repeat (7) begin inc_pulse = 1; step(); end
        sel_pulse = 1; step();
        set_en = 0;
        check_val("alarm_730", alarm_time, 7 * 128 + 3 * 16);

        // trigger and tone
        arm = 1;
        time_in = tval(7, 2, 9, 5, 9); step();
        time_in = tval(7, 3, 0, 0, 0); step();
        check_val("trig_active_n1", alarm_active, 1);
        check_val("trig_buzz_n1", buzzer, 1);
        repeat (4) step();
        check_val("buzz_n5", buzzer, 0);
        repeat (4) step();
        check_val("buzz_n9", buzzer, 1);

        // timeout: 9 active cycles so far
        cnt = 9;
        for (int k = 0; k < 40 && alarm_active === 1'b1; k++) begin
            step();
            if (alarm_active === 1'b1) cnt++;
        end
        check_val("ring_dwell_cycles", cnt, RING_TICKS * TICK_DIV);
        check_val("timeout_buzzer", buzzer, 0);
        repeat (5) step();
        check_val("no_retrigger", alarm_active, 0);

        // snooze cycle
        time_in = tval(7, 3, 0, 0, 1); step();
        time_in = tval(7, 3, 0, 0, 0); step();
        check_val("retrigger", alarm_active, 1);
        step(); step();
        time_in = tval(7, 3, 0, 0, 1);
        snooze_pulse = 1; step();
        check_val("snooze_entry", snoozing, 1);
        check_val("snooze_buzz", buzzer, 0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) snooze_pulse = 1;
            step();
            if (k == 5) check_val("snooze_in_snooze", snoozing, 1);
            if (k == 19) check_val("snooze_still", snoozing, 1);
        end
        check_val("rering_active", alarm_active, 1);
        check_val("rering_buzz", buzzer, 1);

        // priority
        snooze_pulse = 1; dismiss_pulse = 1; step();
        check_val("dismiss_wins_active", alarm_active, 0);
        check_val("dismiss_wins_snooze", snoozing, 0);

        // suppression
        time_in = tval(7, 3, 0, 0, 1); step();
        set_en = 1; time_in = tval(7, 3, 0, 0, 0); step(); step();
        check_val("suppress_set_en", alarm_active, 0);
        set_en = 0; time_in = tval(7, 3, 0, 0, 1); step();
        arm = 0; time_in = tval(7, 3, 0, 0, 0); step(); step();
        check_val("suppress_arm", alarm_active, 0);
        arm = 1;

        // reset mid-snooze
        time_in = tval(7, 3, 0, 0, 1); step();
        time_in = tval(7, 3, 0, 0, 0); step();
        snooze_pulse = 1; step();
        check_val("pre_rst_snooze", snoozing, 1);
        repeat (3) step();
        rst = 1; step(); rst = 0;
        check_val("rst_alarm_time", alarm_time, 0);
        check_val("rst_sel", sel, 0);
        check_val("rst_active", alarm_active, 0);
        check_val("rst_snoozing", snoozing, 0);
        check_val("rst_buzzer", buzzer, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 299) == 0);
            arm           = ($urandom_range(0, 24) != 0);
            set_en        = ($urandom_range(0, 5) == 0);
            sel_pulse     = ($urandom_range(0, 7) == 0);
            inc_pulse     = ($urandom_range(0, 7) == 0);
            dec_pulse     = ($urandom_range(0, 7) == 0);
            snooze_pulse  = ($urandom_range(0, 39) == 0);
            dismiss_pulse = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 7);
            if (r == 0) time_in = {11'(exp_alarm()), 7'd0};
            else if (r == 1) time_in = {11'(exp_alarm()), 3'(0), 4'($urandom_range(1, 9))};
            else if (r == 2) time_in = 18'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
